clken_monitor: RTL and testbench

Checks a clock-enable strobe produced elsewhere in the design, such as a divider's enable output, against its expected rate. It measures the interval between consecutive strobes and reports each measured period. It declares lock after a run of in-tolerance intervals, and flags and counts every out-of-tolerance interval or missing strobe. It sits on the consuming side of a clock-enable net and is used as an in-system rate checker and as a bench monitor.

---
 rtl/clken_monitor.sv | 186 ++++++++++++++++++
 tb/tb_clken_monitor.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/clken_monitor.sv
// Clock-enable rate checker: measures the interval between clken strobes,
// declares lock after a run of in-tolerance periods and flags bad periods or missing strobes.
`timescale 1ns/1ps

module clken_monitor #(
    parameter int unsigned DIV_RATIO  = 16,
    parameter int unsigned TOL        = 1,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clken,
    input  logic             clear,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             err,
    output logic [7:0]       err_cnt
);

    localparam int unsigned E      = DIV_RATIO + 1;
    localparam int unsigned CW1    = CNT_W + 1;
    localparam int unsigned ERR_W  = 8;
    localparam int unsigned G_W    = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT);

    // One extra bit so the tolerance window bounds and cnt+1 never wrap.
    localparam logic [CNT_W:0]   PER_MIN = CW1'(E - TOL);
    localparam logic [CNT_W:0]   PER_MAX = CW1'(E + TOL);
    localparam logic [CNT_W-1:0] CNT_TMO = CNT_W'(E + TOL - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [G_W-1:0]   G_LAST  = G_W'(LOCK_COUNT - 1);
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACQ    = 2'd1,
        S_LOCKED = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [G_W-1:0]     g_q, g_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic               period_valid_q, period_valid_d;
    logic               locked_q, locked_d;
    logic               err_q, err_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;

    logic [CNT_W:0]     meas_c;
    logic               good_c;
    logic               timeout_c;

    // Period measured at a strobe, its tolerance check, and the missing-strobe detect.
    always_comb begin
        meas_c    = {1'b0, cnt_q} + CW1'(1);
        good_c    = (meas_c >= PER_MIN) && (meas_c <= PER_MAX);
        timeout_c = !clken && (cnt_q == CNT_TMO);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (clken) begin
                    state_d = S_ACQ;
                end
            end
            S_ACQ: begin
                if (clken) begin
                    if (good_c && (g_q == G_LAST)) begin
                        state_d = S_LOCKED;
                    end
                end else if (timeout_c) begin
                    state_d = S_IDLE;
                end
            end
            S_LOCKED: begin
                if (clken) begin
                    if (!good_c) begin
                        state_d = S_ACQ;
                    end
                end else if (timeout_c) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d          = cnt_q;
        g_d            = g_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        err_d          = 1'b0;
        err_cnt_d      = err_cnt_q;

        if (clken) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (clken) begin
                    g_d = '0;
                end
            end
            S_ACQ: begin
                if (clken) begin
                    period_d       = CNT_W'(meas_c);
                    period_valid_d = 1'b1;
                    if (good_c) begin
                        g_d = (g_q == G_LAST) ? '0 : g_q + G_W'(1);
                    end else begin
                        err_d = 1'b1;
                        g_d   = '0;
                    end
                end else if (timeout_c) begin
                    err_d = 1'b1;
                    g_d   = '0;
                end
            end
            S_LOCKED: begin
                if (clken) begin
                    period_d       = CNT_W'(meas_c);
                    period_valid_d = 1'b1;
                    if (!good_c) begin
                        err_d = 1'b1;
                        g_d   = '0;
                    end
                end else if (timeout_c) begin
                    err_d = 1'b1;
                    g_d   = '0;
                end
            end
            default: g_d = '0;
        endcase

        locked_d = (state_d == S_LOCKED);

        // clear takes priority over a same-cycle error increment.
        if (clear) begin
            err_cnt_d = '0;
        end else if (err_d && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q          <= '0;
            g_q            <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            err_q          <= 1'b0;
            err_cnt_q      <= '0;
        end else begin
            cnt_q          <= cnt_d;
            g_q            <= g_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            locked_q       <= locked_d;
            err_q          <= err_d;
            err_cnt_q      <= err_cnt_d;
        end
    end

    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign locked       = locked_q;
    assign err          = err_q;
    assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_clken_monitor.sv
// Scoreboard bench for clken_monitor: stimulus queues cycle-stamped expected events,
// a negedge monitor pops and compares whenever period_valid or err is presented.
`timescale 1ns/1ps

module tb_clken_monitor;

    logic       clk;
    logic       rst;
    logic       clken;
    logic       clear;
    logic [7:0] period;
    logic       period_valid;
    logic       locked;
    logic       err;
    logic [7:0] err_cnt;

    typedef struct {
        int cyc;
        bit pv;
        bit er;
        int per;
        bit lk;
        int ec;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   last_strobe = 0;

    clken_monitor #(
        .DIV_RATIO (16),
        .TOL       (1),
        .LOCK_COUNT(4),
        .CNT_W     (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clken       (clken),
        .clear       (clear),
        .period      (period),
        .period_valid(period_valid),
        .locked      (locked),
        .err         (err),
        .err_cnt     (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, pending=%0d", sb.size());
        $fatal(1, "watchdog");
    end

    // Monitor: every presented event must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst && (period_valid || err)) begin
            checks = checks + 1;
            if (sb.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_event cyc=%0d: got pv=%0b err=%0b period=%0d locked=%0b err_cnt=%0d, required no event",
                         cyc, period_valid, err, period, locked, err_cnt);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (cyc != e.cyc || period_valid != e.pv || err != e.er ||
                    int'(period) != e.per || locked != e.lk || int'(err_cnt) != e.ec) begin
                    errors = errors + 1;
                    $display("FAIL event: got cyc=%0d pv=%0b err=%0b period=%0d locked=%0b err_cnt=%0d, required cyc=%0d pv=%0b err=%0b period=%0d locked=%0b err_cnt=%0d",
                             cyc, period_valid, err, period, locked, err_cnt,
                             e.cyc, e.pv, e.er, e.per, e.lk, e.ec);
                end
            end
        end
    end

    task automatic push(input int c, input bit pv, input bit er, input int per, input bit lk, input int ec);
        exp_t e;
        e.cyc = c; e.pv = pv; e.er = er; e.per = per; e.lk = lk; e.ec = ec;
        sb.push_back(e);
    endtask

    task automatic drive0(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            clken = 1'b0;
        end
    endtask

    // Strobe 'gap' cycles after the previous one; ev=0 means no output event expected.
    task automatic strobe(input int gap, input bit ev, input bit er, input int per, input bit lk, input int ec);
        drive0(gap - 1);
        @(negedge clk);
        clken = 1'b1;
        last_strobe = cyc + 1;
        if (ev) push(cyc + 1, 1'b1, er, per, lk, ec);
    endtask

    // Missing strobe: err on the 18th clken=0 edge after the last strobe, period held.
    task automatic expect_timeout(input int per_held, input int ec);
        push(last_strobe + 18, 1'b0, 1'b1, per_held, 1'b0, ec);
    endtask

    task automatic check_zero(input string name);
        checks = checks + 1;
        if (period !== 8'd0 || period_valid !== 1'b0 || locked !== 1'b0 ||
            err !== 1'b0 || err_cnt !== 8'd0) begin
            errors = errors + 1;
            $display("FAIL %s: got period=%0d pv=%0b locked=%0b err=%0b err_cnt=%0d, required all zero",
                     name, period, period_valid, locked, err, err_cnt);
        end
    endtask

    task automatic lock_from_idle(input int ec);
        strobe(5, 1'b0, 1'b0, 0, 1'b0, 0);
        strobe(17, 1'b1, 1'b0, 17, 1'b0, ec);
        strobe(17, 1'b1, 1'b0, 17, 1'b0, ec);
        strobe(17, 1'b1, 1'b0, 17, 1'b0, ec);
        strobe(17, 1'b1, 1'b0, 17, 1'b1, ec);
    endtask

    initial begin
        int ec;
        rst   = 1'b1;
        clken = 1'b0;
        clear = 1'b0;
        #2 rst = 1'b0;
        #1 check_zero("reset_state");
        repeat (3) @(posedge clk);
        @(negedge clk);
        #3 rst = 1'b1;

        // Nominal rate: arm, then four 17-cycle periods lock.
        lock_from_idle(0);

        // Interval of 19 cannot be measured: timeout fires first, the late strobe re-arms.
        expect_timeout(17, 1);
        strobe(19, 1'b0, 1'b0, 0, 1'b0, 0);
        strobe(17, 1'b1, 1'b0, 17, 1'b0, 1);
        strobe(17, 1'b1, 1'b0, 17, 1'b0, 1);
        strobe(17, 1'b1, 1'b0, 17, 1'b0, 1);
        strobe(17, 1'b1, 1'b0, 17, 1'b1, 1);

        // Short interval 15 is measured and rejected while locked.
        strobe(15, 1'b1, 1'b1, 15, 1'b0, 2);
        strobe(17, 1'b1, 1'b0, 17, 1'b0, 2);
        strobe(17, 1'b1, 1'b0, 17, 1'b0, 2);
        strobe(17, 1'b1, 1'b0, 17, 1'b0, 2);
        strobe(17, 1'b1, 1'b0, 17, 1'b1, 2);

        // Stop clken while locked.
        expect_timeout(17, 3);
        drive0(25);

        // Re-arm without period_valid, then tolerance edges 16/18 all accepted.
        strobe(3, 1'b0, 1'b0, 0, 1'b0, 0);
        strobe(16, 1'b1, 1'b0, 16, 1'b0, 3);
        strobe(18, 1'b1, 1'b0, 18, 1'b0, 3);
        strobe(16, 1'b1, 1'b0, 16, 1'b0, 3);
        strobe(18, 1'b1, 1'b0, 18, 1'b1, 3);
        strobe(16, 1'b1, 1'b0, 16, 1'b1, 3);

        // Continuous clken: period 1 every cycle, err_cnt saturates.
        ec = 3;
        for (int i = 0; i < 260; i++) begin
            ec = (ec < 255) ? ec + 1 : 255;
            strobe(1, 1'b1, 1'b1, 1, 1'b0, ec);
        end

        // clear in an err cycle wins over the increment.
        @(negedge clk);
        clken = 1'b1;
        clear = 1'b1;
        last_strobe = cyc + 1;
        push(cyc + 1, 1'b1, 1'b1, 1, 1'b0, 0);
        @(negedge clk);
        clear = 1'b0;
        clken = 1'b1;
        last_strobe = cyc + 1;
        push(cyc + 1, 1'b1, 1'b1, 1, 1'b0, 1);
        expect_timeout(1, 2);
        drive0(20);

        // Async reset between edges while locked.
        lock_from_idle(2);
        drive0(5);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check_zero("async_reset");
        repeat (2) @(posedge clk);
        #1 check_zero("reset_held");
        @(negedge clk);
        #3 rst = 1'b1;

        lock_from_idle(0);
        drive0(10);

        checks = checks + 1;
        if (sb.size() != 0) begin
            errors = errors + 1;
            $display("FAIL pending_events: got %0d unmatched expectations, required 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
